// File: rtl/button_events_pkg.sv
// button_events_pkg
//   Shared definitions for the button event generator: FSM state encoding
//   and the sizing helper for the event timer.
package button_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Bits needed to count 0 .. max(a, b)-1; never less than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_event_timer.sv
// button_event_timer
//   Up-counting cycle timer used by button_events to measure hold and
//   repeat intervals. Synchronous clear has priority over enable.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous clear to zero
//   en     in   increment enable
//   value  out  current count
module button_event_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (en) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_events.sv
// button_events
//   Turns a debounced active-high button level into one-cycle event pulses:
//   press, release, long press and (optionally) auto-repeat. All outputs
//   are registered.
//   Build option: define BUTTON_EVENTS_REPEAT_EN to enable auto-repeat.
//   Without it repeat_pulse is tied low and the timer is sized from
//   HOLD_TICKS alone.
// Parameters:
//   HOLD_TICKS    cycles from press to long press (>= 2)
//   REPEAT_TICKS  cycles between repeat pulses while held (>= 2)
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   level          in   debounced button level, 1 = pressed
//   press          out  one-cycle pulse on press
//   release_pulse  out  one-cycle pulse on release
//   long_press     out  one-cycle pulse when HOLD_TICKS is reached
//   repeat_pulse   out  one-cycle pulse every REPEAT_TICKS while held
//   held           out  high while in HELD
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | button not pressed
// ST_PRESSED | pressed, long press not yet reached
// ST_HELD    | long press reached, repeating if enabled
module button_events
  import button_events_pkg::*;
#(
  parameter int HOLD_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int TW = timer_width(HOLD_TICKS, REPEAT_EN ? REPEAT_TICKS : 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);

  state_t          state;
  logic            lvl_q;
  logic [TW-1:0]   timer;
  logic            timer_clear;
  logic            timer_en;
  logic            hold_hit;
  logic            repeat_hit;

  assign hold_hit = (state == ST_PRESSED) && (timer == HOLD_LAST);

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);
  logic repeat_q;

  assign repeat_hit   = (state == ST_HELD) && (timer == REPEAT_LAST);
  assign repeat_pulse = repeat_q;
`else
  assign repeat_hit   = 1'b0;
  assign repeat_pulse = 1'b0;
`endif

  // The timer restarts on every state entry and threshold; a low level
  // always sends the FSM to IDLE, so clearing on !level covers release.
  assign timer_clear = !level || (state == ST_IDLE) || hold_hit || repeat_hit;
  assign timer_en    = level && ((state == ST_PRESSED) ||
                                 (REPEAT_EN && (state == ST_HELD)));

  button_event_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clear),
    .en    (timer_en),
    .value (timer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      lvl_q         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
    end else begin
      lvl_q         <= level;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      repeat_q      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // Only a fresh rising level counts; a level already high when
          // we arrive here does not re-trigger.
          if (level && !lvl_q) begin
            state <= ST_PRESSED;
            press <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // Release takes precedence over reaching the hold threshold.
          if (!level) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
          end else if (hold_hit) begin
            state      <= ST_HELD;
            long_press <= 1'b1;
            held       <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!level) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (repeat_hit) begin
            repeat_q <= 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_events.md
# button_events

Converts a debounced, active-high button level into single-cycle event pulses: press, release, long-press and (optionally) auto-repeat. It sits directly downstream of the debouncer stage and feeds front-panel control logic, e.g. mode selection and value stepping, with clean one-shot events. All outputs are registered.

## Interface
- `HOLD_TICKS`, default 50_000_000: clock cycles from the press event to the long-press event; must be ≥ 2.
- `REPEAT_TICKS`, default 10_000_000: clock cycles between consecutive repeat events; must be ≥ 2.
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `level`  in  1  debounced button level; 1 = pressed.
- `press`  out  1  one-cycle pulse on a press.
- `release`  out  1  one-cycle pulse on a release.
- `long_press`  out  1  one-cycle pulse when `HOLD_TICKS` is reached.
- `repeat`  out  1  one-cycle pulse every `REPEAT_TICKS` while in HELD.
- `held`  out  1  level; 1 while in state HELD.

## Operation
- Internal registers:
  - `lvl_q` holds `level` from the previous edge.
  - `timer` is sized `$clog2(max(HOLD_TICKS, REPEAT_TICKS))` bits and counts up only.
- FSM states:
  - IDLE: button not pressed.
  - PRESSED: pressed, long-press not yet reached.
  - HELD: long-press reached.
- Transitions, evaluated on each rising edge:
  - IDLE, `level`=1, `lvl_q`=0 → PRESSED. Set `press`; `timer` ← 0.
  - PRESSED, `level`=1, `timer`=`HOLD_TICKS`−1 → HELD. Set `long_press`; `timer` ← 0.
  - PRESSED, `level`=1 otherwise → stay. `timer` increments.
  - HELD, `level`=1, `timer`=`REPEAT_TICKS`−1 → stay. Set `repeat`; `timer` ← 0.
  - HELD, `level`=1 otherwise → stay. `timer` increments.
  - PRESSED or HELD, `level`=0 → IDLE. Set `release`; `timer` ← 0.
- Event outputs default to 0 on every edge where they are not set, so each pulse lasts exactly one cycle.
- Release in the same cycle as the hold or repeat threshold: release wins; no `long_press` or `repeat` is produced.
- At most one event pulse is high in any cycle.
- A press is recognised only from IDLE. Re-pressing requires a full release first.

## Timing
- Reset values: all outputs 0, state IDLE, `timer` 0, `lvl_q` 0.
- `level` rises before edge E0 → `press` is high in the cycle after E0.
- Hold held continuously → `long_press` is high exactly `HOLD_TICKS` cycles after `press`.
- First `repeat` comes `REPEAT_TICKS` cycles after `long_press`; later pulses follow every `REPEAT_TICKS` cycles.
- `level` falls before edge Er → `release` is high in the cycle after Er; `held` drops in that same cycle.
- Reset asserted mid-operation: immediate return to reset values, no release pulse. After deassertion with `level`=1, `lvl_q` is 0, so a fresh `press` is generated.
- `level` is already synchronous and debounced; no extra synchronisation is added.

## Configuration
- Macro `BUTTON_EVENTS_REPEAT_EN`.
- Defined: repeat behaviour as described above.
- Undefined:
  - `repeat` is tied to 0.
  - `timer` is sized from `HOLD_TICKS` only.
  - HELD stays in HELD without counting, so `timer` holds 0.
- `held`, `long_press`, `press` and `release` are identical in both builds.

## Structure
- Package `button_events_pkg`:
  - FSM state encoding: IDLE=2'd0, PRESSED=2'd1, HELD=2'd2.
  - Width helper function for `timer`.
- Sub-module `button_event_timer`:
  - Parameterised width.
  - Inputs: synchronous `clear`, `en`.
  - Output: `value`.
  - Shares `clk` and `rst_n` with the parent.
- The FSM and output registers stay in the top module.

## Test plan
- Test parameters: `HOLD_TICKS`=5, `REPEAT_TICKS`=3.
- Short press (`level`=1 for 3 cycles, then 0):
  - `press` 1 cycle after the rise; `release` 1 cycle after the fall.
  - No `long_press`; `held` never 1.
- Long hold (`level`=1 for 20 cycles):
  - `long_press` 5 cycles after `press`.
  - `repeat` at +3, +6, +9, … after that (REPEAT_EN build).
  - `held`=1 from the `long_press` cycle until `release`.
- `level` falls exactly on the threshold edge (1 for 5 cycles): `release` only, no `long_press`.
- `rst_n` pulsed low during HELD with `level` still 1:
  - Outputs 0 immediately.
  - After deassertion, `press` 1 cycle later, then `long_press` 5 cycles after that.
- Build without `BUTTON_EVENTS_REPEAT_EN`, 20-cycle hold: `repeat` stays 0 and `long_press` fires once.
